// File: rtl/legv8_bus_pkg.sv
// Shared definitions for the LEGv8 memory-port arbiter: FSM encoding,
// requester IDs and default bus widths.
package legv8_bus_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bus_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arbiter_2
    import legv8_bus_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_id_o
);
    always_comb begin
        grant_valid_o = req0_i | req1_i;
        if (req0_i && req1_i)
            grant_id_o = ~last_grant_i;
        else if (req1_i)
            grant_id_o = REQ_DMA;
        else
            grant_id_o = REQ_CPU;
    end
endmodule

// File: rtl/legv8_mem_bus_arbiter.sv
// Shares one LEGv8 memory port between the CPU (port 0) and a DMA master
// (port 1): round-robin grant, latched request, fixed wait-state count.
module legv8_mem_bus_arbiter
    import legv8_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_drive,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    bus_state_e        state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant_id_q, grant_id_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              arb_valid, arb_id;

    rr_arbiter_2 u_arb (
        .req0_i        (cpu_req),
        .req1_i        (dma_req),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (arb_valid),
        .grant_id_o    (arb_id)
    );

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d    = ACCESS;
                    wait_cnt_d = WS_LOAD;
                    grant_id_d = arb_id;
                    if (arb_id == REQ_DMA) begin
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                // Read data is sampled on the final access cycle.
                if (wait_cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (grant_id_q == REQ_DMA)
                            dma_rdata_d = mem_rdata;
                        else
                            cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            DONE: begin
                last_grant_d = grant_id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            grant_id_q   <= REQ_CPU;
            last_grant_q <= REQ_DMA;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    always_comb begin
        mem_addr  = (state_q == IDLE) ? '0 : addr_q;
        mem_wdata = (state_q == IDLE) ? '0 : wdata_q;
        mem_we    = (state_q == ACCESS) && we_q;
        mem_drive = (state_q == ACCESS) && we_q;
        mem_oe    = (state_q == ACCESS) && !we_q;
        cpu_ack   = (state_q == DONE) && (grant_id_q == REQ_CPU);
        dma_ack   = (state_q == DONE) && (grant_id_q == REQ_DMA);
        busy      = (state_q != IDLE);
        grant_id  = grant_id_q;
        cpu_rdata = cpu_rdata_q;
        dma_rdata = dma_rdata_q;
    end
endmodule

// File: tb/tb_legv8_mem_bus_arbiter.sv
// Self-checking bench for legv8_mem_bus_arbiter: a WAIT_STATES=1 instance and a
// WAIT_STATES=0 instance share stimulus; completions are matched to a queue.
module tb_legv8_mem_bus_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] cpu_addr = '0, dma_addr = '0;
    logic [63:0] cpu_wdata = '0, dma_wdata = '0, mem_rdata = '0;

    logic [63:0] cpu_rdata, dma_rdata, mem_wdata;
    logic [31:0] mem_addr;
    logic        cpu_ack, dma_ack, mem_drive, mem_we, mem_oe, busy, grant_id;

    logic [63:0] c0_rdata, d0_rdata, m0_wdata;
    logic [31:0] m0_addr;
    logic        c0_ack, d0_ack, m0_drive, m0_we, m0_oe, busy0, gid0;

    typedef struct {
        bit          port;
        logic [63:0] rdata;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int passes = 0;
    int total  = 0;

    always #5 clock = ~clock;

    legv8_mem_bus_arbiter #(.ADDR_W(32), .DATA_W(64), .WAIT_STATES(1)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_drive(mem_drive),
        .mem_we(mem_we), .mem_oe(mem_oe), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    legv8_mem_bus_arbiter #(.ADDR_W(32), .DATA_W(64), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(c0_rdata), .cpu_ack(c0_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(d0_rdata), .dma_ack(d0_ack),
        .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_drive(m0_drive),
        .mem_we(m0_we), .mem_oe(m0_oe), .mem_rdata(mem_rdata),
        .busy(busy0), .grant_id(gid0)
    );

    // Bounded wait for the next ack; n=20 means it never came.
    task automatic wait_ack(input bit use0, output int n, output bit port);
        n = 0;
        port = 1'b0;
        while (n < 20) begin
            @(negedge clock);
            n++;
            if (!use0 && (cpu_ack || dma_ack)) begin port = dma_ack; return; end
            if (use0 && (c0_ack || d0_ack)) begin port = d0_ack; return; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if ({busy, grant_id, cpu_ack, dma_ack, mem_we, mem_oe, mem_drive} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy, grant_id, cpu_ack, dma_ack, mem_we, mem_oe, mem_drive});
        else passes++;
        total++;
        if ({cpu_rdata, dma_rdata} !== 128'h0)
            $display("FAIL reset_rdata: got %h %h want 0 0", cpu_rdata, dma_rdata);
        else passes++;
        total++;
        if ({mem_addr, mem_wdata} !== 96'h0)
            $display("FAIL reset_mem: got %h %h want 0 0", mem_addr, mem_wdata);
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_cpu_read();
        mem_rdata = 64'hDEADBEEF;
        cpu_we = 1'b0; cpu_addr = 32'h100; cpu_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            total++;
            if ({mem_oe, mem_we, mem_drive} !== ((c < 3) ? 3'b100 : 3'b000))
                $display("FAIL cpu_read_strobe c%0d: got %b", c, {mem_oe, mem_we, mem_drive});
            else passes++;
            total++;
            if ({cpu_ack, dma_ack} !== ((c == 3) ? 2'b10 : 2'b00))
                $display("FAIL cpu_read_ack c%0d: got %b", c, {cpu_ack, dma_ack});
            else passes++;
            if (c == 1) begin
                total++;
                if (mem_addr !== 32'h100 || busy !== 1'b1 || grant_id !== 1'b0)
                    $display("FAIL cpu_read_addr: got %h busy %b gid %b want 100 1 0",
                             mem_addr, busy, grant_id);
                else passes++;
            end
        end
        total++;
        if (cpu_rdata !== 64'hDEADBEEF)
            $display("FAIL cpu_read_data: got %h want deadbeef", cpu_rdata);
        else passes++;
        cpu_req = 1'b0;
        @(negedge clock);
        total++;
        if (busy !== 1'b0) $display("FAIL cpu_read_idle: got busy %b want 0", busy);
        else passes++;
    endtask

    task automatic test_dma_write();
        dma_we = 1'b1; dma_addr = 32'h200; dma_wdata = 64'h55; dma_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            total++;
            if (grant_id !== 1'b1) $display("FAIL dma_wr_gid c%0d: got %b want 1", c, grant_id);
            else passes++;
            if (c < 3) begin
                total++;
                if ({mem_we, mem_drive, mem_oe} !== 3'b110 || mem_addr !== 32'h200 ||
                    mem_wdata !== 64'h55 || dma_ack !== 1'b0)
                    $display("FAIL dma_wr_bus c%0d: got %b %h %h ack %b want 110 200 55 0",
                             c, {mem_we, mem_drive, mem_oe}, mem_addr, mem_wdata, dma_ack);
                else passes++;
            end else begin
                total++;
                if ({dma_ack, cpu_ack, mem_we, mem_drive, mem_oe} !== 5'b10000)
                    $display("FAIL dma_wr_done: got %b want 10000",
                             {dma_ack, cpu_ack, mem_we, mem_drive, mem_oe});
                else passes++;
                total++;
                if (cpu_rdata !== 64'hDEADBEEF || dma_rdata !== 64'h0)
                    $display("FAIL dma_wr_rdata: got %h %h want deadbeef 0", cpu_rdata, dma_rdata);
                else passes++;
            end
        end
        dma_req = 1'b0; dma_we = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_tie();
        int  n;
        bit  p;
        exp_t e;
        reset = 1'b1; @(negedge clock); reset = 1'b0;
        sb.push_back('{1'b0, 64'h1111, 3});
        sb.push_back('{1'b1, 64'h2222, 4});
        sb.push_back('{1'b0, 64'h3333, 4});
        mem_rdata = 64'h1111;
        cpu_we = 1'b0; dma_we = 1'b0; cpu_req = 1'b1; dma_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1'b0, n, p);
            e = sb.pop_front();
            total++;
            if (p !== e.port || n !== e.lat)
                $display("FAIL tie_order k%0d: got port %0d after %0d want port %0d after %0d",
                         k, p, n, e.port, e.lat);
            else passes++;
            total++;
            if ((p ? dma_rdata : cpu_rdata) !== e.rdata)
                $display("FAIL tie_rdata k%0d: got %h want %h", k,
                         p ? dma_rdata : cpu_rdata, e.rdata);
            else passes++;
            if (sb.size() != 0) mem_rdata = sb[0].rdata;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        total++;
        if (dma_rdata !== 64'h2222) $display("FAIL tie_hold: got %h want 2222", dma_rdata);
        else passes++;
        @(negedge clock);
    endtask

    task automatic test_addr_latch();
        cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 64'hAA; cpu_req = 1'b1;
        @(negedge clock);
        total++;
        if (mem_addr !== 32'h10) $display("FAIL latch_c1: got %h want 10", mem_addr);
        else passes++;
        cpu_addr = 32'h20; cpu_wdata = 64'hBB; cpu_we = 1'b0; cpu_req = 1'b0;
        @(negedge clock);
        total++;
        if (mem_addr !== 32'h10 || mem_wdata !== 64'hAA || mem_we !== 1'b1 || mem_oe !== 1'b0)
            $display("FAIL latch_c2: got %h %h we %b oe %b want 10 aa 1 0",
                     mem_addr, mem_wdata, mem_we, mem_oe);
        else passes++;
        @(negedge clock);
        total++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 64'h3333)
            $display("FAIL latch_ack: got ack %b rdata %h want 1 3333", cpu_ack, cpu_rdata);
        else passes++;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  p;
        exp_t e;
        mem_rdata = 64'h9999;
        cpu_we = 1'b0; cpu_addr = 32'h300; cpu_req = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if (busy !== 1'b1 || mem_oe !== 1'b1)
            $display("FAIL rmid_pre: got busy %b oe %b want 1 1", busy, mem_oe);
        else passes++;
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clock);
        total++;
        if ({busy, cpu_ack, dma_ack, mem_we, mem_oe, mem_drive, grant_id} !== 7'b0 ||
            cpu_rdata !== 64'h0)
            $display("FAIL rmid_post: got %b rdata %h want 0000000 0",
                     {busy, cpu_ack, dma_ack, mem_we, mem_oe, mem_drive, grant_id}, cpu_rdata);
        else passes++;
        reset = 1'b0;
        mem_rdata = 64'h4444;
        cpu_req = 1'b1; dma_req = 1'b1;
        sb.push_back('{1'b0, 64'h4444, 3});
        wait_ack(1'b0, n, p);
        e = sb.pop_front();
        cpu_req = 1'b0; dma_req = 1'b0;
        total++;
        if (p !== e.port || n !== e.lat || cpu_rdata !== e.rdata)
            $display("FAIL rmid_tie: got port %0d after %0d rdata %h want %0d after %0d %h",
                     p, n, cpu_rdata, e.port, e.lat, e.rdata);
        else passes++;
        @(negedge clock);
    endtask

    task automatic test_ws0();
        int  n;
        bit  p;
        exp_t e;
        reset = 1'b1; @(negedge clock); reset = 1'b0;
        sb.push_back('{1'b0, 64'h70, 2});
        sb.push_back('{1'b0, 64'h71, 3});
        sb.push_back('{1'b0, 64'h72, 3});
        mem_rdata = 64'h70;
        cpu_we = 1'b0; cpu_addr = 32'h400; cpu_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1'b1, n, p);
            e = sb.pop_front();
            total++;
            if (p !== e.port || n !== e.lat || c0_rdata !== e.rdata)
                $display("FAIL ws0 k%0d: got port %0d after %0d rdata %h want %0d after %0d %h",
                         k, p, n, c0_rdata, e.port, e.lat, e.rdata);
            else passes++;
            if (sb.size() != 0) mem_rdata = sb[0].rdata;
        end
        cpu_req = 1'b0;
        @(negedge clock);
        total++;
        if (busy0 !== 1'b0 || m0_addr !== 32'h0)
            $display("FAIL ws0_idle: got busy %b addr %h want 0 0", busy0, m0_addr);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_tie();
        test_addr_latch();
        test_reset_mid();
        test_ws0();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, total);
        $fatal(1);
    end
endmodule
